// File: rtl/bus_recorder.sv
// bus_recorder: captures cartridge-bus read/write strobes as 4-byte records, queues them
// in a small FIFO and streams them into the recording RAM. Optional timestamp byte: BUS_RECORDER_TIMESTAMP_EN.
module bus_recorder #(
  parameter int RAM_ADR_WIDTH = 12,
  parameter int FIFO_DEPTH    = 4,
  parameter int TS_PRESCALE   = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [14:0]              bus_adr,
  input  logic [7:0]               bus_data,
  input  logic                     bus_rd,
  input  logic                     bus_wr,
  input  logic                     bus_cs_rom,
  input  logic                     bus_cs_xram,
  output logic [RAM_ADR_WIDTH-1:0] ram_adr,
  output logic [7:0]               ram_data,
  output logic                     ram_we,
  input  logic [1:0]               adr,
  input  logic                     cs,
  input  logic                     rd,
  input  logic                     wr,
  input  logic [7:0]               data_in,
  output logic [7:0]               data_out
);

  localparam int PTR_W = RAM_ADR_WIDTH - 2;
  localparam int FA_W  = $clog2(FIFO_DEPTH);
  localparam logic [FA_W:0] FIFO_FULL_CNT = (FA_W+1)'(FIFO_DEPTH);
  localparam logic [FA_W:0] FIFO_ONE      = (FA_W+1)'(1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TS_PRESCALE < 1 ||
      RAM_ADR_WIDTH < 3) begin : g_param_check
    $error("bus_recorder: invalid parameter set");
  end

  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} wstate_t;

  // Input stage (s1) plus one-cycle history (s2) for edge detection
  logic [14:0] s1_adr, s2_adr;
  logic [7:0]  s1_data, s2_data;
  logic        s1_rd, s2_rd, s1_wr, s2_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_adr <= '0; s2_adr <= '0; s1_data <= '0; s2_data <= '0;
      s1_rd  <= 1'b0; s2_rd <= 1'b0; s1_wr <= 1'b0; s2_wr <= 1'b0;
    end else begin
      s1_adr <= bus_adr; s1_data <= bus_data; s1_rd <= bus_rd; s1_wr <= bus_wr;
      s2_adr <= s1_adr;  s2_data <= s1_data;  s2_rd <= s1_rd;  s2_wr <= s1_wr;
    end
  end

  logic        arm, wrap, ovf, full, wrapped;
  logic [15:0] count;
  logic [PTR_W-1:0] rec_ptr;
  wstate_t     state;

  logic [31:0]     fifo_mem [FIFO_DEPTH];
  logic [FA_W-1:0] fifo_wp, fifo_rp;
  logic [FA_W:0]   fifo_cnt;

  logic ctrl_wr, arm_rise, ev_wr, ev_rd, capture, push, drop, pop, rec_last, stop;
  logic fifo_ne, fifo_full, more_queued, busy;
  logic [7:0]  byte3;
  logic [31:0] rec, head;
  logic [1:0]  byte_idx;
  logic [7:0]  out_byte;
  logic        data_in_unused;

  assign ctrl_wr  = cs & wr & (adr == 2'd0);
  assign arm_rise = ctrl_wr & data_in[0] & ~arm;
  assign data_in_unused = ^data_in[7:2];

  // A write edge wins over a simultaneous read edge
  assign ev_wr   = s2_wr & ~s1_wr;
  assign ev_rd   = s2_rd & ~s1_rd;
  assign capture = (ev_wr | ev_rd) & arm & ~full & ~arm_rise;

  assign fifo_ne   = (fifo_cnt != '0);
  assign fifo_full = (fifo_cnt == FIFO_FULL_CNT);
  assign push      = capture & ~fifo_full;
  assign drop      = capture & fifo_full;
  assign pop       = (state == B3);
  assign rec_last  = (rec_ptr == '1);
  assign stop      = pop & rec_last & ~wrap;
  assign more_queued = (fifo_cnt > FIFO_ONE) | push;
  assign busy      = arm | fifo_ne | (state != IDLE);

  assign rec  = {byte3, s2_data, ev_wr, s2_adr[14:8], s2_adr[7:0]};
  assign head = fifo_mem[fifo_rp];

`ifdef BUS_RECORDER_TIMESTAMP_EN
  localparam int PS_W = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;
  logic [PS_W-1:0] ts_pre;
  logic            ts_tick;
  logic [7:0]      ts_delta;
  logic            cs_unused;

  assign cs_unused = bus_cs_rom ^ bus_cs_xram;
  assign ts_tick   = (ts_pre == PS_W'(TS_PRESCALE - 1));

  // A tick coinciding with a capture counts toward the next delta
  always_ff @(posedge clk) begin
    if (reset || arm_rise) begin
      ts_pre   <= '0;
      ts_delta <= '0;
    end else begin
      ts_pre <= ts_tick ? '0 : ts_pre + 1'b1;
      if (push)
        ts_delta <= {7'b0, ts_tick};
      else if (ts_tick && ts_delta != 8'hff)
        ts_delta <= ts_delta + 8'd1;
    end
  end

  assign byte3 = ts_delta;
`else
  logic s1_rom, s1_xram, s2_rom, s2_xram;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_rom <= 1'b0; s1_xram <= 1'b0; s2_rom <= 1'b0; s2_xram <= 1'b0;
    end else begin
      s1_rom <= bus_cs_rom; s1_xram <= bus_cs_xram;
      s2_rom <= s1_rom;     s2_xram <= s1_xram;
    end
  end

  assign byte3 = {s2_rom, s2_xram, 6'b0};
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wp] <= rec;
  end

  always_comb begin
    byte_idx = 2'd0;
    out_byte = 8'h00;
    case (state)
      B0: begin byte_idx = 2'd0; out_byte = head[7:0];   end
      B1: begin byte_idx = 2'd1; out_byte = head[15:8];  end
      B2: begin byte_idx = 2'd2; out_byte = head[23:16]; end
      B3: begin byte_idx = 2'd3; out_byte = head[31:24]; end
      default: ;
    endcase
  end

  // RAM port is a registered copy of the writer state, so it trails the state by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      arm <= 1'b0; wrap <= 1'b0; ovf <= 1'b0; full <= 1'b0; wrapped <= 1'b0;
      count <= '0; rec_ptr <= '0; state <= IDLE;
      fifo_wp <= '0; fifo_rp <= '0; fifo_cnt <= '0;
      ram_we <= 1'b0; ram_adr <= '0; ram_data <= '0;
    end else begin
      if (ctrl_wr) begin
        arm  <= data_in[0];
        wrap <= data_in[1];
      end
      ram_we   <= (state != IDLE) & ~arm_rise;
      ram_adr  <= {rec_ptr, byte_idx};
      ram_data <= out_byte;

      if (arm_rise) begin
        ovf <= 1'b0; full <= 1'b0; wrapped <= 1'b0;
        count <= '0; rec_ptr <= '0; state <= IDLE;
        fifo_wp <= '0; fifo_rp <= '0; fifo_cnt <= '0;
      end else begin
        if (drop || (stop && more_queued)) ovf <= 1'b1;

        if (stop) begin
          fifo_wp <= '0; fifo_rp <= '0; fifo_cnt <= '0;
        end else begin
          if (push) fifo_wp <= fifo_wp + 1'b1;
          if (pop)  fifo_rp <= fifo_rp + 1'b1;
          case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + FIFO_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - FIFO_ONE;
            default: ;
          endcase
        end

        case (state)
          IDLE: if (fifo_ne) state <= B0;
          B0:   state <= B1;
          B1:   state <= B2;
          B2:   state <= B3;
          B3: begin
            if (count != 16'hffff) count <= count + 16'd1;
            if (rec_last) begin
              rec_ptr <= '0;
              if (wrap) wrapped <= 1'b1;
              else      full    <= 1'b1;
            end else begin
              rec_ptr <= rec_ptr + 1'b1;
            end
            state <= (!stop && more_queued) ? B0 : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    data_out = 8'hff;
    if (cs && rd) begin
      case (adr)
        2'd0: data_out = {ovf, 5'b0, wrap, arm};
        2'd1: data_out = count[7:0];
        2'd2: data_out = count[15:8];
        2'd3: data_out = {4'b0, fifo_ne, wrapped, full, busy};
        default: data_out = 8'hff;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_recorder.sv
// tb_bus_recorder: directed-vector bench for bus_recorder with a byte-wide RAM model
// fed from the recording write port.
module tb_bus_recorder;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] bus_adr;
  logic [7:0]  bus_data;
  logic        bus_rd, bus_wr, bus_cs_rom, bus_cs_xram;
  logic [11:0] ram_adr;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic [1:0]  adr;
  logic        cs, rd, wr;
  logic [7:0]  data_in, data_out;

  bus_recorder #(.RAM_ADR_WIDTH(12), .FIFO_DEPTH(4), .TS_PRESCALE(12)) dut (
    .clk(clk), .reset(reset),
    .bus_adr(bus_adr), .bus_data(bus_data), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_cs_rom(bus_cs_rom), .bus_cs_xram(bus_cs_xram),
    .ram_adr(ram_adr), .ram_data(ram_data), .ram_we(ram_we),
    .adr(adr), .cs(cs), .rd(rd), .wr(wr), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

`ifdef BUS_RECORDER_TIMESTAMP_EN
  localparam int A_B3 = 'h00;
  localparam int B_B3 = 'h00;
`else
  localparam int A_B3 = 'h40;
  localparam int B_B3 = 'h80;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // RAM model, sampled on the falling edge
  logic [7:0] mem [0:4095];
  int cyc = 0;
  int log_adr[$];
  int log_dat[$];
  int log_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (ram_we === 1'b1) begin
      mem[ram_adr] = ram_data;
      log_adr.push_back(int'(ram_adr));
      log_dat.push_back(int'(ram_data));
      log_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    adr = a; data_in = d; cs = 1'b1; wr = 1'b1;
    step();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
    adr = a; cs = 1'b1; rd = 1'b1;
    #1 d = data_out;
    cs = 1'b0; rd = 1'b0;
    #1;
  endtask

  task automatic bus_ev(input logic w, input logic r, input logic [14:0] a, input logic [7:0] d,
                        input logic rom, input logic xram);
    bus_adr = a; bus_data = d; bus_wr = w; bus_rd = r; bus_cs_rom = rom; bus_cs_xram = xram;
    step();
    bus_adr = '0; bus_data = '0; bus_wr = 1'b0; bus_rd = 1'b0; bus_cs_rom = 1'b0; bus_cs_xram = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int base;
    int exp_a [4];
    int found;

    reset = 1'b1;
    bus_adr = '0; bus_data = '0; bus_rd = 1'b0; bus_wr = 1'b0; bus_cs_rom = 1'b0; bus_cs_xram = 1'b0;
    adr = '0; cs = 1'b0; rd = 1'b0; wr = 1'b0; data_in = '0;
    step(3);
    reset = 1'b0;
    step(1);

    check("rst_ram_we", int'(ram_we), 0);
    check("rst_ram_adr", int'(ram_adr), 0);
    check("rst_ram_data", int'(ram_data), 0);
    check("deselected_ff", int'(data_out), 'hff);
    cpu_rd(2'd0, v); check("rst_ctrl", int'(v), 0);
    cpu_rd(2'd3, v); check("rst_status", int'(v), 0);

    // Single write at 0x2000 with external-RAM select
    base = log_adr.size();
    cpu_wr(2'd0, 8'h01);
    cpu_rd(2'd3, v); check("armed_busy", int'(v), 'h01);
    bus_ev(1'b1, 1'b0, 15'h2000, 8'h0a, 1'b0, 1'b1);
    step(10);
    exp_a = '{'h00, 'ha0, 'h0a, A_B3};
    check("a_nwrites", log_adr.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("a_adr%0d", i), log_adr[base+i], i);
      check($sformatf("a_dat%0d", i), log_dat[base+i], exp_a[i]);
    end
    check("a_consecutive", log_cyc[base+3] - log_cyc[base], 3);
    cpu_rd(2'd1, v); check("a_count_lo", int'(v), 1);
    cpu_rd(2'd2, v); check("a_count_hi", int'(v), 0);
    cpu_wr(2'd0, 8'h00);
    step(1);
    cpu_rd(2'd3, v); check("a_disarmed_status", int'(v), 0);

    // Read at 0x0150 with ROM select
    base = log_adr.size();
    cpu_wr(2'd0, 8'h01);
    bus_ev(1'b0, 1'b1, 15'h0150, 8'h3c, 1'b1, 1'b0);
    step(10);
    check("b_nwrites", log_adr.size() - base, 4);
    check("b_byte0", int'(mem[0]), 'h50);
    check("b_byte1", int'(mem[1]), 'h01);
    check("b_byte2", int'(mem[2]), 'h3c);
    check("b_byte3", int'(mem[3]), B_B3);

    // Read and write strobes falling together
    cpu_wr(2'd0, 8'h00); cpu_wr(2'd0, 8'h01);
    base = log_adr.size();
    bus_ev(1'b1, 1'b1, 15'h1234, 8'h77, 1'b0, 1'b0);
    step(10);
    check("sim_nwrites", log_adr.size() - base, 4);
    check("sim_byte0", int'(mem[0]), 'h34);
    check("sim_byte1", int'(mem[1]), 'h92);
    check("sim_byte2", int'(mem[2]), 'h77);
    cpu_rd(2'd1, v); check("sim_count", int'(v), 1);

    // Six events on consecutive cycles (alternating wr/rd pulses): four fit, two dropped
    cpu_wr(2'd0, 8'h00); cpu_wr(2'd0, 8'h01);
    base = log_adr.size();
    for (int i = 0; i < 6; i++) begin
      bus_adr = 15'h100 + 15'(i); bus_data = 8'h10 + 8'(i);
      bus_wr = (i % 2 == 0); bus_rd = (i % 2 == 1);
      step();
    end
    bus_wr = 1'b0; bus_rd = 1'b0; bus_adr = '0; bus_data = '0;
    step(40);
    check("ovf_nwrites", log_adr.size() - base, 16);
    cpu_rd(2'd1, v); check("ovf_count", int'(v), 4);
    cpu_rd(2'd0, v); check("ovf_ctrl", int'(v), 'h81);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_r%0d_b0", i), int'(mem[4*i]), i);
      check($sformatf("ovf_r%0d_b1", i), int'(mem[4*i+1]), (i % 2 == 0) ? 'h81 : 'h01);
      check($sformatf("ovf_r%0d_b2", i), int'(mem[4*i+2]), 'h10 + i);
    end

`ifdef BUS_RECORDER_TIMESTAMP_EN
    cpu_wr(2'd0, 8'h00); cpu_wr(2'd0, 8'h01);
    bus_ev(1'b1, 1'b0, 15'h0011, 8'h01, 1'b0, 1'b0);
    step(35);
    bus_ev(1'b1, 1'b0, 15'h0022, 8'h02, 1'b0, 1'b0);
    step(4999);
    bus_ev(1'b1, 1'b0, 15'h0033, 8'h03, 1'b0, 1'b0);
    step(10);
    check("ts_delta_36cyc", int'(mem[7]), 3);
    check("ts_delta_sat", int'(mem[11]), 255);
`endif

    // 1025 events, no wrap: the last one must not be recorded
    cpu_wr(2'd0, 8'h00); cpu_wr(2'd0, 8'h01);
    base = log_adr.size();
    for (int k = 0; k < 1025; k++) begin
      bus_ev(1'b1, 1'b0, 15'(k), 8'(k) ^ 8'h5a, 1'b0, 1'b0);
      step(7);
    end
    step(10);
    check("nowrap_nwrites", log_adr.size() - base, 4096);
    cpu_rd(2'd1, v); check("nowrap_count_lo", int'(v), 'h00);
    cpu_rd(2'd2, v); check("nowrap_count_hi", int'(v), 'h04);
    cpu_rd(2'd3, v); check("nowrap_status", int'(v), 'h03);
    cpu_rd(2'd0, v); check("nowrap_ctrl", int'(v), 'h01);
    check("nowrap_rec0_b1", int'(mem[1]), 'h80);
    check("nowrap_last_b0", int'(mem[4092]), 'hff);
    check("nowrap_last_b1", int'(mem[4093]), 'h83);

    // Same with wrap: the 1025th lands on record 0
    cpu_wr(2'd0, 8'h00); cpu_wr(2'd0, 8'h03);
    base = log_adr.size();
    for (int k = 0; k < 1025; k++) begin
      bus_ev(1'b1, 1'b0, 15'(k), 8'(k) ^ 8'h5a, 1'b0, 1'b0);
      step(7);
    end
    step(10);
    check("wrap_nwrites", log_adr.size() - base, 4100);
    cpu_rd(2'd1, v); check("wrap_count_lo", int'(v), 'h01);
    cpu_rd(2'd2, v); check("wrap_count_hi", int'(v), 'h04);
    cpu_rd(2'd3, v); check("wrap_status", int'(v), 'h05);
    check("wrap_rec0_b0", int'(mem[0]), 'h00);
    check("wrap_rec0_b1", int'(mem[1]), 'h84);
    check("wrap_rec0_b2", int'(mem[2]), 'h5a);

    // Reset while the writer is in B2 (RAM port showing byte 1)
    bus_ev(1'b1, 1'b0, 15'h0055, 8'h66, 1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (ram_we === 1'b1 && ram_adr[1:0] == 2'd1) found = 1;
    end
    check("b2_reached", found, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_b2_ram_we", int'(ram_we), 0);
    reset = 1'b0;
    step(1);
    check("rst_b2_ram_we_hold", int'(ram_we), 0);
    cpu_rd(2'd0, v); check("rst_b2_ctrl", int'(v), 0);
    cpu_rd(2'd1, v); check("rst_b2_count_lo", int'(v), 0);
    cpu_rd(2'd2, v); check("rst_b2_count_hi", int'(v), 0);
    cpu_rd(2'd3, v); check("rst_b2_status", int'(v), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
